// File: rtl/rfid_read_sequencer_if.sv
// Start/result handshake between the dispenser main FSM
// and the RFID read sequencer.
interface rfid_read_sequencer_if;
    logic        start;
    logic        busy;
    logic        result_valid;
    logic        match;
    logic [2:0]  match_idx;
    logic [31:0] tag_out;
    logic        timeout_err;

    modport master (
        output start,
        input  busy, result_valid, match,
        input  match_idx, tag_out, timeout_err
    );

    modport slave (
        input  start,
        output busy, result_valid, match,
        output match_idx, tag_out, timeout_err
    );
endinterface

// File: rtl/rfid_read_sequencer.sv
// Triggers the UART tag receiver, captures the UID and looks it
// up in a small table of registered users, with timeout/retry.
module rfid_read_sequencer #(
    parameter int N_USERS        = 4,
    parameter int IDX_W          = 3,
    parameter int TRIG_CYCLES    = 5000,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int MAX_RETRY      = 2
) (
    input  logic               clk,
    input  logic               RST,
    rfid_read_sequencer_if.slave bus,
    input  logic               uart_done,
    input  logic [31:0]        uart_tag,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [31:0]        wr_tag,
    input  logic               wr_clr,
    output logic               uart_rst_n
);
    typedef enum logic [2:0] {
        IDLE, TRIG, WAIT_LOW, WAIT_HIGH,
        CAPTURE, COMPARE, REPORT, RETRY
    } state_t;

    localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYCLES - 1);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

    state_t             state;
    logic               done_m, done_s;
    logic               trig_n;
    logic [31:0]        trig_cnt, to_cnt;
    logic [7:0]         attempts;
    logic               busy_q, rv_q, match_q, terr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        tag_q;
    logic [N_USERS-1:0] tbl_vld;
    logic [31:0]        tbl_tag [N_USERS];
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;

    // Trigger is released combinationally so reset frees the receiver at once
    assign uart_rst_n       = trig_n | ~RST;
    assign bus.busy         = busy_q;
    assign bus.result_valid = rv_q;
    assign bus.match        = match_q;
    assign bus.match_idx    = idx_q;
    assign bus.tag_out      = tag_q;
    assign bus.timeout_err  = terr_q;

    always_ff @(posedge clk) begin
        if (!RST) begin
            done_m <= 1'b0;
            done_s <= 1'b0;
        end else begin
            done_m <= uart_done;
            done_s <= done_m;
        end
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            tbl_vld <= '0;
            for (int i = 0; i < N_USERS; i++) tbl_tag[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < N_USERS; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    tbl_vld[i] <= ~wr_clr;
                    if (!wr_clr) tbl_tag[i] <= wr_tag;
                end
            end
        end
    end

    // Descending scan so the lowest matching index wins
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_USERS - 1; i >= 0; i--) begin
            if (tbl_vld[i] && tbl_tag[i] == tag_q) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            state    <= IDLE;
            trig_n   <= 1'b1;
            busy_q   <= 1'b0;
            rv_q     <= 1'b0;
            match_q  <= 1'b0;
            idx_q    <= '0;
            tag_q    <= '0;
            terr_q   <= 1'b0;
            trig_cnt <= '0;
            to_cnt   <= '0;
            attempts <= '0;
        end else begin
            rv_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= TRIG;
                        busy_q   <= 1'b1;
                        trig_n   <= 1'b0;
                        trig_cnt <= '0;
                        attempts <= 8'd1;
                    end
                end
                TRIG: begin
                    if (trig_cnt == TRIG_LAST) begin
                        trig_n <= 1'b1;
                        to_cnt <= '0;
                        state  <= WAIT_LOW;
                    end else begin
                        trig_cnt <= trig_cnt + 32'd1;
                    end
                end
                WAIT_LOW: begin
                    if (!done_s) begin
                        to_cnt <= to_cnt + 32'd1;
                        state  <= WAIT_HIGH;
                    end else if (to_cnt == TO_LAST) begin
                        state <= RETRY;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (done_s) begin
                        state <= CAPTURE;
                    end else if (to_cnt == TO_LAST) begin
                        state <= RETRY;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                CAPTURE: begin
                    tag_q <= uart_tag;
                    state <= (uart_tag == 32'd0) ? RETRY : COMPARE;
                end
                COMPARE: begin
                    rv_q    <= 1'b1;
                    match_q <= hit;
                    idx_q   <= hit_idx;
                    terr_q  <= 1'b0;
                    state   <= REPORT;
                end
                RETRY: begin
                    if (attempts <= RETRY_MAX) begin
                        state    <= TRIG;
                        trig_n   <= 1'b0;
                        trig_cnt <= '0;
                        attempts <= attempts + 8'd1;
                    end else begin
                        rv_q    <= 1'b1;
                        match_q <= 1'b0;
                        idx_q   <= '0;
                        terr_q  <= 1'b1;
                        state   <= REPORT;
                    end
                end
                REPORT: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/rfid_read_sequencer.md
# rfid_read_sequencer

Sequences RFID UID reads through the 32-bit UART tag receiver and authorizes dispensing. On a `start` request it pulses the receiver's read trigger, waits for a fresh `done`, then compares the captured UID against a small programmable table of registered users. It reports match/no-match with the matching index, and retries on timeout or an all-zero UID. It sits between the dispenser main FSM and the UART receiver; the main FSM sees only a `start` / `result_valid` handshake.

## Interface
- `N_USERS`, 4: table depth (1..8); `IDX_W` = 3 fixed.
- `TRIG_CYCLES`, 5000: cycles `uart_rst_n` is held low per trigger (must exceed one receiver baud tick).
- `TIMEOUT_CYCLES`, 50_000_000: max cycles from trigger release to fresh `done`.
- `MAX_RETRY`, 2: extra attempts after the first.
- `clk` in 1: system clock, rising edge.
- `RST` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle read request from the main FSM.
- `uart_done` in 1: receiver `done`, asynchronous to `clk`.
- `uart_tag` in 32: receiver UID, stable while `uart_done`=1.
- `wr_en` in 1: table write strobe.
- `wr_idx` in 3: table entry index; writes with `wr_idx` ≥ `N_USERS` are ignored.
- `wr_tag` in 32: UID to store.
- `wr_clr` in 1: when 1 with `wr_en`, invalidates the entry instead of storing.
- `uart_rst_n` out 1: drives the receiver's read trigger, active-low.
- `busy` out 1: high from `start` acceptance until `result_valid`.
- `result_valid` out 1: one-cycle completion pulse.
- `match` out 1: UID found; valid while `result_valid`=1, then held.
- `match_idx` out 3: lowest matching entry index, 0 when no match.
- `tag_out` out 32: last captured UID.
- `timeout_err` out 1: completion was a failure after all retries.

## Operation
- `uart_done` passes through a 2-flop synchronizer (`done_s`) before any use.
- States:
  - IDLE → TRIG on `start`.
  - TRIG: `uart_rst_n`=0 for `TRIG_CYCLES`, then → WAIT_LOW.
  - WAIT_LOW: wait for `done_s`=0 (the stale `done` from the previous read clears), then → WAIT_HIGH.
  - WAIT_HIGH: on `done_s`=1 → CAPTURE.
  - CAPTURE: latch `uart_tag` into `tag_out`. Zero UID → RETRY; otherwise → COMPARE.
  - COMPARE: one cycle; parallel compare against all valid entries; lowest index wins → REPORT.
  - REPORT: `result_valid`=1 for one cycle → IDLE.
  - RETRY: if attempts ≤ `MAX_RETRY` → TRIG; else set `timeout_err`=1, `match`=0 → REPORT.
- Timeout counter: cleared on entering WAIT_LOW; counts in WAIT_LOW and WAIT_HIGH. Reaching `TIMEOUT_CYCLES`-1 → RETRY.
- Attempt counter: cleared on `start` acceptance, incremented on each TRIG entry.
- `start` while `busy` is ignored. `start` in the same cycle as REPORT is ignored.
- Table: `N_USERS` × (valid bit + 32-bit UID), cleared on reset. Writes are accepted in any state. A write in the COMPARE cycle takes effect after it: the compare uses the pre-write contents.
- A stored UID of 0 never matches, because CAPTURE diverts zero UIDs to RETRY.

## Timing
- Reset values: `uart_rst_n`=1, `busy`=0, `result_valid`=0, `match`=0, `match_idx`=0, `tag_out`=0, `timeout_err`=0; all table entries invalid; state IDLE.
- Reset mid-operation: returns to IDLE next edge, releases `uart_rst_n` immediately, and emits no `result_valid`.
- `start` sampled at edge k → `busy`=1 and `uart_rst_n`=0 from edge k+1.
- `uart_rst_n` returns to 1 exactly `TRIG_CYCLES` cycles after it fell.
- `done` edge to CAPTURE: 2 synchronizer cycles + 1.
- CAPTURE → COMPARE → REPORT: `result_valid` is 3 cycles after `done_s` rises in WAIT_HIGH.
- `busy` falls in the cycle after `result_valid`.
- `match`, `match_idx`, `timeout_err` update with `result_valid` and hold until the next completion.

## Test plan
- Table entry 1 = 0xA1B2C3D4 (valid). `start`; model asserts `done` with tag 0xA1B2C3D4 after 1000 cycles → `result_valid` pulse, `match`=1, `match_idx`=1, `tag_out`=0xA1B2C3D4, `timeout_err`=0.
- Entries 0 and 3 both = 0x11223344. Read returns that UID → `match_idx`=0.
- Model never asserts `done`; `TIMEOUT_CYCLES`=100, `MAX_RETRY`=2 → three `uart_rst_n` low pulses of `TRIG_CYCLES` each, then `result_valid` with `timeout_err`=1, `match`=0.
- First read returns 0x00000000, second returns 0xDEADBEEF (not in table) → two triggers, `match`=0, `timeout_err`=0, `tag_out`=0xDEADBEEF.
- `done` left high from the previous read. New `start` → no CAPTURE until `done` falls then rises; a second `start` while `busy` produces no extra trigger.
- `RST`=0 during WAIT_HIGH → next edge: `uart_rst_n`=1, `busy`=0, no `result_valid`. Table write with `wr_idx`=5 (`N_USERS`=4) → no entry changes.
